// File: rtl/cpu_pkg.sv
// Shared definitions for the microprocessor front end:
// opcode encodings, the control-strobe bundle and the datapath width.
package cpu_pkg;

    localparam int DATA_W = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_LW  = 2'b01;
    localparam logic [1:0] OP_SW  = 2'b10;
    localparam logic [1:0] OP_JMP = 2'b11;

    // The first field is the MSB, so a control vector reads in the same
    // order as the decode table.
    typedef struct packed {
        logic reg_dst;
        logic reg_write;
        logic alu_src;
        logic branch;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic alu_op;
    } ctrl_t;

endpackage

// File: rtl/clk_divider.sv
// Divides the board clock by 2*HALF_PERIOD to produce the slow processor clock.
// The output comes straight from a flop, so it is glitch-free.
module clk_divider #(
    parameter logic [31:0] HALF_PERIOD = 32'd25_000_000
) (
    input  logic clk_in,
    input  logic reset,
    output logic clk_out
);

    localparam logic [31:0] TERMINAL = HALF_PERIOD - 32'd1;

    logic [31:0] cnt;

    // Count board-clock edges and toggle the output at the end of each half-period.
    // Reset takes priority, even in the middle of a period.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else if (cnt == TERMINAL) begin
            cnt     <= '0;
            clk_out <= ~clk_out;
        end else begin
            cnt     <= cnt + 32'd1;
        end
    end

endmodule

// File: rtl/cpu_ctrl_alu_clkgen.sv
// Front-end support block: clock divider, main-control decoder and adder ALU.
// The decoder and ALU are purely combinational and ignore reset.
module cpu_ctrl_alu_clkgen
    import cpu_pkg::*;
#(
    parameter logic [31:0] HALF_PERIOD = 32'd25_000_000,
    parameter int          WIDTH       = DATA_W
) (
    input  logic             clk_in,
    input  logic             reset,
    output logic             clk_out,
    input  logic [1:0]       op,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src,
    output logic             branch,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             alu_op,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic [WIDTH-1:0] result
);

    ctrl_t ctrl;

    clk_divider #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_div (
        .clk_in (clk_in),
        .reset  (reset),
        .clk_out(clk_out)
    );

    // Decode the opcode into control strobes; unused fields and unknown
    // opcodes fall back to all-zero so nothing gets written by accident.
    always_comb begin
        ctrl = '0;
        case (op)
            OP_ADD:  ctrl = ctrl_t'(8'b1100_0001);
            OP_LW:   ctrl = ctrl_t'(8'b0110_1010);
            OP_SW:   ctrl = ctrl_t'(8'b0010_0100);
            OP_JMP:  ctrl = ctrl_t'(8'b0001_0000);
            default: ctrl = '0;
        endcase
    end

    assign reg_dst    = ctrl.reg_dst;
    assign reg_write  = ctrl.reg_write;
    assign alu_src    = ctrl.alu_src;
    assign branch     = ctrl.branch;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign alu_op     = ctrl.alu_op;

    // The adder wraps modulo 2^WIDTH and discards the carry-out.
    assign result = operand1 + operand2;

endmodule

// File: tb/tb_cpu_ctrl_alu_clkgen.sv
// Directed self-checking bench: two divider configurations, the decoder, the ALU
// and reset isolation.
module tb_cpu_ctrl_alu_clkgen;

    logic       clk_in = 1'b0;
    logic       reset  = 1'b1;
    logic [1:0] op     = 2'b00;
    logic [7:0] operand1 = 8'h00;
    logic [7:0] operand2 = 8'h00;

    logic       clk_out3, clk_out1;
    logic       reg_dst, reg_write, alu_src, branch;
    logic       mem_read, mem_write, mem_to_reg, alu_op;
    logic [7:0] result;

    logic       b_reg_dst, b_reg_write, b_alu_src, b_branch;
    logic       b_mem_read, b_mem_write, b_mem_to_reg, b_alu_op;
    logic [7:0] b_result;

    int errors = 0;
    int checks = 0;

    always #5 clk_in = ~clk_in;

    cpu_ctrl_alu_clkgen #(.HALF_PERIOD(32'd3), .WIDTH(8)) dut_hp3 (
        .clk_in(clk_in), .reset(reset), .clk_out(clk_out3), .op(op),
        .reg_dst(reg_dst), .reg_write(reg_write), .alu_src(alu_src),
        .branch(branch), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .alu_op(alu_op),
        .operand1(operand1), .operand2(operand2), .result(result)
    );

    cpu_ctrl_alu_clkgen #(.HALF_PERIOD(32'd1), .WIDTH(8)) dut_hp1 (
        .clk_in(clk_in), .reset(reset), .clk_out(clk_out1), .op(op),
        .reg_dst(b_reg_dst), .reg_write(b_reg_write), .alu_src(b_alu_src),
        .branch(b_branch), .mem_read(b_mem_read), .mem_write(b_mem_write),
        .mem_to_reg(b_mem_to_reg), .alu_op(b_alu_op),
        .operand1(operand1), .operand2(operand2), .result(b_result)
    );

    wire [7:0] ctrl_vec = {reg_dst, reg_write, alu_src, branch,
                           mem_read, mem_write, mem_to_reg, alu_op};

    // One rising edge, then settle before sampling or driving.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (clk_out3 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_hp3: got %b want 0", clk_out3);
        end
        checks++;
        if (clk_out1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_hp1: got %b want 0", clk_out1);
        end
    endtask

    task automatic test_divider_hp3();
        logic exp;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            step();
            exp = ((k / 3) % 2) == 1;
            checks++;
            if (clk_out3 !== exp) begin
                errors++;
                $display("[TB] FAIL div_hp3 edge %0d: got %b want %b", k, clk_out3, exp);
            end
        end
    endtask

    task automatic test_divider_hp1();
        logic exp;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            exp = (k % 2) == 1;
            checks++;
            if (clk_out1 !== exp) begin
                errors++;
                $display("[TB] FAIL div_hp1 edge %0d: got %b want %b", k, clk_out1, exp);
            end
        end
    endtask

    task automatic test_mid_period_reset();
        logic exp;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) step();
        checks++;
        if (clk_out3 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_pre_high: got %b want 1", clk_out3);
        end
        reset = 1'b1;
        step();
        checks++;
        if (clk_out3 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_edge: got %b want 0", clk_out3);
        end
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            exp = (k >= 3);
            checks++;
            if (clk_out3 !== exp) begin
                errors++;
                $display("[TB] FAIL mid_restart edge %0d: got %b want %b", k, clk_out3, exp);
            end
        end
    endtask

    task automatic test_control();
        logic [1:0] ops  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [7:0] vecs [4] = '{8'b1100_0001, 8'b0110_1010, 8'b0010_0100, 8'b0001_0000};
        for (int i = 0; i < 4; i++) begin
            op = ops[i];
            #1;
            checks++;
            if (ctrl_vec !== vecs[i]) begin
                errors++;
                $display("[TB] FAIL ctrl op=%b: got %b want %b", ops[i], ctrl_vec, vecs[i]);
            end
        end
        op = 2'bxx;
        #1;
        if ($isunknown(op)) begin
            checks++;
            if (ctrl_vec !== 8'h00) begin
                errors++;
                $display("[TB] FAIL ctrl op=xx: got %b want 00000000", ctrl_vec);
            end
        end else begin
            $display("[TB] op=xx not representable in this simulator, unknown-opcode case not checked");
        end
        op = 2'b00;
    endtask

    task automatic test_alu();
        logic [7:0] a [5] = '{8'h03, 8'h05, 8'hFF, 8'h80, 8'h7F};
        logic [7:0] b [5] = '{8'h04, 8'hFF, 8'h01, 8'h80, 8'h01};
        logic [7:0] s [5] = '{8'h07, 8'h04, 8'h00, 8'h00, 8'h80};
        for (int i = 0; i < 5; i++) begin
            operand1 = a[i];
            operand2 = b[i];
            #1;
            checks++;
            if (result !== s[i]) begin
                errors++;
                $display("[TB] FAIL alu %h+%h: got %h want %h", a[i], b[i], result, s[i]);
            end
        end
    endtask

    task automatic test_reset_isolation();
        op       = 2'b01;
        operand1 = 8'h10;
        operand2 = 8'h02;
        reset    = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            reset = (k == 1);
            step();
            checks++;
            if (ctrl_vec !== 8'b0110_1010) begin
                errors++;
                $display("[TB] FAIL iso_ctrl step %0d: got %b want 01101010", k, ctrl_vec);
            end
            checks++;
            if (result !== 8'h12) begin
                errors++;
                $display("[TB] FAIL iso_result step %0d: got %h want 12", k, result);
            end
        end
        checks++;
        if (clk_out1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL iso_div_cleared: got %b want 1", clk_out1);
        end
        reset = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_divider_hp3();
        test_divider_hp1();
        test_mid_period_reset();
        test_control();
        test_alu();
        test_reset_isolation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
